// File: rtl/bin_a_bcd.sv
// rtl/bin_a_bcd.sv - signed binary to five-digit BCD converter (iterative double dabble)
// Leading-zero blank mask is generated only when BIN_A_BCD_BLANK_EN is defined.
module bin_a_bcd #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic         neg,
  output logic [19:0]  bcd,
  output logic [4:0]   blank
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  mag, mag_nxt;
  logic [19:0]   scratch, adj, scr_nxt;
  logic          sign;
  logic          last;

  assign last = (state == S_CONV) && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CONV;
      S_CONV:  if (last)  state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift {scratch, mag} left.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 5; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    {scr_nxt, mag_nxt} = {adj[18:0], mag, 1'b0};
  end

  // Results load on the final shift so they are valid in the same cycle as done.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      mag     <= '0;
      scratch <= '0;
      sign    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      neg     <= 1'b0;
      bcd     <= '0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= (state_nxt == S_FIN);
      case (state)
        S_IDLE: begin
          if (start) begin
            mag     <= bin[N-1] ? (~bin + 1'b1) : bin;
            sign    <= bin[N-1];
            scratch <= '0;
            cnt     <= CW'(N);
          end
        end
        S_CONV: begin
          scratch <= scr_nxt;
          mag     <= mag_nxt;
          cnt     <= cnt - 1'b1;
          if (last) begin
            bcd <= scr_nxt;
            neg <= sign;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BIN_A_BCD_BLANK_EN
  function automatic logic [4:0] blank_mask(input logic [19:0] d);
    logic [4:0] m;
    m[0] = 1'b0;
    m[4] = (d[19:16] == 4'd0);
    for (int i = 3; i >= 1; i--) m[i] = m[i+1] && (d[4*i +: 4] == 4'd0);
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)       blank <= 5'b11110;
    else if (last) blank <= blank_mask(scr_nxt);
  end
`else
  assign blank = 5'b00000;
`endif

endmodule

// File: tb/tb_bin_a_bcd.sv
// tb/tb_bin_a_bcd.sv - directed self-checking bench for bin_a_bcd
module tb_bin_a_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic        neg;
  logic [19:0] bcd;
  logic [4:0]  blank;

  int total = 0;
  int bad   = 0;

`ifdef BIN_A_BCD_BLANK_EN
  localparam logic [4:0] BL_RST  = 5'b11110;
  localparam logic [4:0] BL_ZERO = 5'b11110;
  localparam logic [4:0] BL_ONE  = 5'b11110;
  localparam logic [4:0] BL_HUND = 5'b11000;
`else
  localparam logic [4:0] BL_RST  = 5'b00000;
  localparam logic [4:0] BL_ZERO = 5'b00000;
  localparam logic [4:0] BL_ONE  = 5'b00000;
  localparam logic [4:0] BL_HUND = 5'b00000;
`endif

  bin_a_bcd #(.N(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .neg   (neg),
    .bcd   (bcd),
    .blank (blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge (cycle 0); returns at the negedge after the done cycle.
  task automatic convert(input logic [15:0] v, input logic [19:0] e_bcd,
                         input logic e_neg, input logic [4:0] e_blank);
    int n;
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    #1 start = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) check("busy_c1", 32'(busy), 32'd1);
      if (done) break;
    end
    check("latency", 32'(n), 32'd17);
    check("bcd", 32'(bcd), 32'(e_bcd));
    check("neg", 32'(neg), 32'(e_neg));
    check("blank", 32'(blank), 32'(e_blank));
    check("busy_fin", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    int first_c;
    int second_c;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_blank", 32'(blank), 32'(BL_RST));
    rst = 1'b0;
    @(negedge clk);

    convert(16'h0000, 20'h00000, 1'b0, BL_ZERO);
    convert(16'h4000, 20'h16384, 1'b0, 5'b00000);
    convert(16'hC080, 20'h16256, 1'b1, 5'b00000);
    convert(16'h0007, 20'h00007, 1'b0, BL_ONE);
    convert(16'h8000, 20'h32768, 1'b1, 5'b00000);
    convert(16'hFFFF, 20'h00001, 1'b1, BL_ONE);

    // Starts in cycles 5 and 17 are ignored; the one in cycle 18 is accepted.
    ndone    = 0;
    first_c  = 0;
    second_c = 0;
    start    = 1'b1;
    bin      = 16'd291;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_c = c;
          check("ign_bcd1", 32'(bcd), 32'h00291);
          check("ign_blank1", 32'(blank), 32'(BL_HUND));
        end else if (ndone == 2) begin
          second_c = c;
          check("ign_bcd2", 32'(bcd), 32'h00999);
          check("ign_neg2", 32'(neg), 32'd0);
        end
      end
      start = (c == 5) || (c == 17) || (c == 18);
      bin   = (c == 5) ? 16'h1111 : (c == 17) ? 16'h2222 : (c == 18) ? 16'd999 : 16'h0000;
    end
    start = 1'b0;
    check("ign_ndone", 32'(ndone), 32'd2);
    check("ign_first_c", 32'(first_c), 32'd17);
    check("ign_second_c", 32'(second_c), 32'd35);

    // Reset in cycle 8 aborts the conversion without a done.
    start = 1'b1;
    bin   = 16'h3039;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    check("abort_busy_c8", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_neg", 32'(neg), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_nodone", 32'(ndone), 32'd0);

    convert(16'h3039, 20'h12345, 1'b0, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin_a_bcd.md
# bin_a_bcd

Sequential signed binary-to-BCD converter that sits directly downstream of the Booth multiplier. It accepts the 16-bit two's-complement product `Mult` when the multiplier signals `done`. It converts the magnitude to five BCD digits with an iterative shift-and-add-3 (double dabble) engine and presents sign, digits and a leading-zero blank mask to the 7-segment display driver. It processes one conversion at a time with a start/busy/done handshake.

## Interface
- `N`, 16: width of the binary input; the digit count is fixed at 5, which is sufficient for magnitudes up to 65535.
- `clk` in 1: system clock; all logic is on `posedge clk`.
- `rst` in 1: reset, synchronous and active-high; one clock; no other clock or reset.
- `start` in 1: one-cycle request; sampled only in IDLE. Tied to multiplier `done`.
- `bin` in N: two's-complement value, sampled on the cycle `start` is accepted.
- `busy` out 1: high from the cycle after acceptance through the `done` cycle.
- `done` out 1: one-cycle pulse; the result outputs are valid from this cycle.
- `neg` out 1: 1 when the captured `bin` was negative.
- `bcd` out 20: five BCD digits; `[19:16]` is the ten-thousands digit and `[3:0]` is the units digit.
- `blank` out 5: per-digit blank mask; bit i corresponds to `bcd[4i+3:4i]`.

## Operation
- FSM states: IDLE, CONV, FIN; the state encoding is internal.
- IDLE:
  - If `start`=1, capture `mag` = `bin[N-1]` ? (~`bin`+1) : `bin` as N-bit unsigned. 0x8000 yields 32768; no overflow occurs.
  - Capture `sign` = `bin[N-1]`, clear the 20-bit scratch digit register, load iteration counter = N, and go to CONV.
- CONV, once per cycle:
  - Each scratch digit ≥5 gets +3.
  - Shift {scratch, `mag`} left by 1.
  - Decrement the counter.
  - When the counter reaches 0 after this update, go to FIN.
  - This gives exactly N CONV cycles.
- FIN:
  - Register `bcd` ← scratch, `neg` ← `sign`, `blank` ← computed mask.
  - Assert `done`, then go to IDLE unconditionally.
- `start` in CONV or FIN is ignored and not queued.
- Outputs `bcd`, `neg` and `blank` hold their last result until the next FIN; they are not disturbed during CONV.
- Zero input gives `neg`=0. Negative zero cannot occur.
- `rst` at any cycle, including mid-CONV, aborts the conversion and applies the reset values; no `done` is produced for the aborted conversion.
- Reset values: `busy`=0, `done`=0, `neg`=0, `bcd`=0x00000, `blank`=5'b11110 with the macro or 5'b00000 without it. The state returns to IDLE and the counter is cleared.

## Timing
- `start` accepted at the edge ending cycle 0.
- CONV occupies cycles 1..N (1..16).
- FIN and `done`=1 occur in cycle N+1 (17).
- The earliest next accept is cycle N+2.
- Throughput is one conversion per N+2 cycles.
- `busy`=1 in cycles 1..N+1; `busy`=0 in IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `BIN_A_BCD_BLANK_EN`.
- Defined:
  - `blank[i]`=1 when digit i and all higher digits are zero, for i=4..1.
  - `blank[0]` is always 0, so the units digit is always shown.
  - The reset value of `blank` is 5'b11110.
- Undefined:
  - No blanking logic is synthesized.
  - `blank` is tied to 5'b00000 at all times, including reset.

## Test plan
- `bin`=0x0000 → `done` in cycle 17; `bcd`=0x00000, `neg`=0, `blank`=11110 (EN) or 00000 (no EN).
- `bin`=0x4000 (16384, −128×−128) → `bcd`=0x16384, `neg`=0, `blank`=00000.
- `bin`=0xC080 (−16256, −128×127) → `bcd`=0x16256, `neg`=1; then `bin`=0x0007 → `bcd`=0x00007, `neg`=0, `blank`=11110 (EN).
- `bin`=0x8000 → `bcd`=0x32768, `neg`=1; `bin`=0xFFFF → `bcd`=0x00001, `neg`=1, `blank`=11110 (EN).
- `start` pulses with new `bin` values in cycles 5 and 17 → ignored; exactly one `done` pulse, carrying the first value; a `start` in cycle 18 is accepted, with `done` in cycle 35.
- `rst` asserted in cycle 8 of a conversion of 0x3039 → the next cycle has `busy`=0, `bcd`=0, `neg`=0, and no `done`; a restart with 0x3039 → `bcd`=0x12345.
